// File: rtl/fma_result_collector.sv
// fma_result_collector: captures results from a fixed-latency FP32 FMA,
// tags each with its IEEE-754 class, and buffers them in a first-word
// fall-through FIFO. Credits toward the issuer reserve a FIFO slot for
// every op in flight, so a capture never finds the FIFO full.
module fma_result_collector #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [WIDTH-1:0]         fma_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 4;

  // Credit counter, op-tracking shift register and FIFO state
  logic [CW-1:0]      r_credits;
  logic [LATENCY-1:0] r_vld;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [EW-1:0]      r_mem [DEPTH];

  logic               w_fire;
  logic               w_pop;
  logic               w_push;
  logic [3:0]         w_flags;
  logic [EW-1:0]      w_head;

  // IEEE-754 single-precision class: {nan, inf, zero, denorm}
  function automatic logic [3:0] fp32_class(input logic [31:0] v);
    logic [7:0]  e;
    logic [22:0] m;
    e = v[30:23];
    m = v[22:0];
    fp32_class[3] = (e == 8'hFF) && (m != 23'd0);
    fp32_class[2] = (e == 8'hFF) && (m == 23'd0);
    fp32_class[1] = (e == 8'h00) && (m == 23'd0);
    fp32_class[0] = (e == 8'h00) && (m != 23'd0);
  endfunction

  // Handshake and FIFO control decode
  always_comb begin
    issue_ready = (r_credits != '0) && !rst;
    w_fire      = issue_valid && issue_ready;
    out_valid   = (r_count != '0);
    w_pop       = out_valid && out_ready;
    w_push      = r_vld[LATENCY-1];
    w_flags     = fp32_class(fma_result[31:0]);
    w_head      = r_mem[r_rd_ptr];
    // Storage is not reset, so the head is masked to zero while empty
    out_data    = out_valid ? w_head[EW-1:4] : '0;
    out_flags   = out_valid ? w_head[3:0]    : 4'd0;
    occupancy   = r_count;
  end

  // Credits: a fire consumes one, a pop returns one
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= CW'(DEPTH);
    end else if (w_fire && !w_pop) begin
      r_credits <= r_credits - 1'b1;
    end else if (!w_fire && w_pop) begin
      r_credits <= r_credits + 1'b1;
    end
  end

  // Valid shift register marks which FMA pipeline slots hold real ops
  generate
    if (LATENCY == 1) begin : g_vld_single
      always_ff @(posedge clk) begin
        if (rst) r_vld <= '0;
        else     r_vld <= w_fire;
      end
    end else begin : g_vld_multi
      always_ff @(posedge clk) begin
        if (rst) r_vld <= '0;
        else     r_vld <= {r_vld[LATENCY-2:0], w_fire};
      end
    end
  endgenerate

  // Result storage: captured value with its class flags alongside
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {fma_result, w_flags};
    end
  end

  // FIFO pointers (wrap naturally at DEPTH, a power of two) and count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_fma_result_collector.sv
// Directed bench for fma_result_collector (LATENCY=3, DEPTH=4). A small
// FMA model delays each fired op's result by LATENCY cycles onto
// fma_result and drives garbage in every other cycle.
module tb_fma_result_collector;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam logic [31:0] GARBAGE = 32'hBAD0BAD0;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] fma_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [2:0]  occupancy;

  int          n_vec;
  int          n_err;
  int          n_fire;
  int          base;
  int          max_occ;
  logic [31:0] cur_op;
  logic [31:0] pipe_val [LAT];
  logic        pipe_v   [LAT];

  fma_result_collector #(.LATENCY(LAT), .DEPTH(DEPTH), .WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .fma_result  (fma_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flags   (out_flags),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("  ok %s = %h", tag, obs);
    end
  endtask

  // One clock: sample the handshake mid-cycle, then advance the FMA model
  task automatic tick();
    logic fire_s;
    @(negedge clk);
    fire_s = issue_valid && issue_ready;
    @(posedge clk);
    #1;
    if (fire_s) n_fire++;
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i]   = pipe_v[i-1];
      pipe_val[i] = pipe_val[i-1];
    end
    pipe_v[0]   = fire_s;
    pipe_val[0] = cur_op;
    fma_result  = pipe_v[LAT-1] ? pipe_val[LAT-1] : GARBAGE;
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] data, input logic [3:0] flags);
    out_ready = 1'b1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  out_data, data);
    check({tag, "_flags"}, 32'(out_flags), 32'(flags));
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_fire = 0; max_occ = 0;
    rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0;
    cur_op = 32'd0; fma_result = GARBAGE;
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_val[i] = 32'd0;
    end

    // Reset state
    tick(); tick();
    check("rst_issue_ready", 32'(issue_ready), 32'd0);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_occupancy",   32'(occupancy),   32'd0);
    check("rst_out_data",    out_data,         32'd0);
    check("rst_out_flags",   32'(out_flags),   32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(issue_ready), 32'd1);

    // Single op: output appears after edge 3
    issue_valid = 1'b1; cur_op = 32'h40A00000;
    tick();
    issue_valid = 1'b0;
    tick(); tick();
    check("single_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("single_occ", 32'(occupancy), 32'd1);
    pop_check("single", 32'h40A00000, 4'b0000);
    check("single_occ_after_pop", 32'(occupancy), 32'd0);

    // Back-to-back three ops
    issue_valid = 1'b1;
    cur_op = 32'h40A00000; tick();
    cur_op = 32'h41200000; tick();
    cur_op = 32'h7FC00000; tick();
    issue_valid = 1'b0;
    tick();
    check("b2b_occ1", 32'(occupancy), 32'd1);
    tick();
    check("b2b_occ2", 32'(occupancy), 32'd2);
    tick();
    check("b2b_occ3", 32'(occupancy), 32'd3);
    pop_check("b2b0", 32'h40A00000, 4'b0000);
    pop_check("b2b1", 32'h41200000, 4'b0000);
    pop_check("b2b2", 32'h7FC00000, 4'b1000);
    check("b2b_empty", 32'(occupancy), 32'd0);

    // Credit stall with the consumer blocked
    base = n_fire; max_occ = 0;
    issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cur_op = 32'h3F800000 + 32'(i);
      tick();
      if (i == 3) check("stall_ready_low", 32'(issue_ready), 32'd0);
      if (i == 5) check("stall_occ3", 32'(occupancy), 32'd3);
      if (i == 6) check("stall_occ4", 32'(occupancy), 32'd4);
    end
    check("stall_fires", 32'(n_fire - base), 32'd4);
    out_ready = 1'b1; cur_op = 32'h40400000;
    tick();
    out_ready = 1'b0;
    check("stall_pop_occ", 32'(occupancy), 32'd3);
    check("stall_ready_back", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    check("stall_fires_plus1", 32'(n_fire - base), 32'd5);
    check("stall_ready_again", 32'(issue_ready), 32'd0);
    tick(); tick(); tick();
    check("stall_refill_occ", 32'(occupancy), 32'd4);
    check("stall_max_occ", 32'(max_occ), 32'd4);
    pop_check("drain0", 32'h3F800001, 4'b0000);
    pop_check("drain1", 32'h3F800002, 4'b0000);
    pop_check("drain2", 32'h3F800003, 4'b0000);
    pop_check("drain3", 32'h40400000, 4'b0000);
    check("drain_empty", 32'(occupancy), 32'd0);

    // Bubbles: fires on edges 0 and 2 only
    issue_valid = 1'b1; cur_op = 32'h3F800000; tick();
    issue_valid = 1'b0; cur_op = 32'h12345678; tick();
    issue_valid = 1'b1; cur_op = 32'h40000000; tick();
    issue_valid = 1'b0; cur_op = 32'h87654321;
    for (int i = 0; i < 5; i++) tick();
    check("bubble_occ", 32'(occupancy), 32'd2);
    pop_check("bubble0", 32'h3F800000, 4'b0000);
    pop_check("bubble1", 32'h40000000, 4'b0000);
    check("bubble_empty", 32'(occupancy), 32'd0);

    // Class flags
    issue_valid = 1'b1;
    cur_op = 32'h80000000; tick();
    cur_op = 32'h7F800000; tick();
    cur_op = 32'h00000001; tick();
    issue_valid = 1'b0;
    tick(); tick(); tick();
    check("class_occ", 32'(occupancy), 32'd3);
    pop_check("class_negzero", 32'h80000000, 4'b0010);
    pop_check("class_inf",     32'h7F800000, 4'b0100);
    pop_check("class_denorm",  32'h00000001, 4'b0001);

    // Reset with two buffered and two in flight
    issue_valid = 1'b1;
    cur_op = 32'h3F800000; tick();
    cur_op = 32'h40000000; tick();
    cur_op = 32'h40400000; tick();
    cur_op = 32'h40800000; tick();
    issue_valid = 1'b0;
    tick();
    check("mid_occ_before_rst", 32'(occupancy), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_ready_low", 32'(issue_ready), 32'd0);
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    check("mid_rst_ready_held", 32'(issue_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_post_ready", 32'(issue_ready), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("mid_no_capture", 32'(occupancy), 32'd0);
    base = n_fire;
    issue_valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    issue_valid = 1'b0;
    check("mid_credits_full", 32'(n_fire - base), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
